// File: rtl/spi_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_arbiter_if
// Brief    : Requester-side bus of the two-port SPI register arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_reg_arbiter_if;
    logic [1:0]  req_in;
    logic [9:0]  reg_in;
    logic [1:0]  wr_in;
    logic [15:0] wdata_in;
    logic [1:0]  grant_out;
    logic [1:0]  done_out;
    logic [7:0]  rdata_out;
    logic        busy_out;
    logic [7:0]  status_out;

    modport master (
        output req_in, reg_in, wr_in, wdata_in,
        input  grant_out, done_out, rdata_out, busy_out, status_out
    );

    modport slave (
        input  req_in, reg_in, wr_in, wdata_in,
        output grant_out, done_out, rdata_out, busy_out, status_out
    );
endinterface
`default_nettype wire

// File: rtl/spi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_arbiter
// Brief    : Round-robin arbiter of two requesters onto one 16-bit SPI
//            register access to a MAX3421E. Define SPI_ARB_STATUS_EN to
//            capture the chip status byte on status_out.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_arbiter #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 10
) (
    input  logic              clk_in,
    input  logic              rst_in,
    spi_reg_arbiter_if.slave  bus,
    output logic              ss_out,
    output logic              sclk_out,
    output logic              mosi_out,
    input  logic              miso_in
);

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [9:0] c_GAP_LAST = 10'(GAP_CYCLES - 1);
`ifdef SPI_ARB_STATUS_EN
    localparam int         c_RX_W     = 16;
`else
    localparam int         c_RX_W     = 8;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_END   = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              r_state;
    logic [7:0]          r_div;
    logic [3:0]          r_bit;
    logic [9:0]          r_gap;
    logic [15:0]         r_tx;
    logic [c_RX_W-1:0]   r_rx;
    logic                r_last;
    logic [1:0]          r_grant;
    logic [1:0]          r_done;
    logic [7:0]          r_rdata;
    logic                r_busy;
    logic                r_ss;
    logic                r_sclk;
    logic                r_mosi;

    logic                w_win;
    logic [4:0]          w_reg;
    logic                w_wr;
    logic [7:0]          w_wdata;
    logic [15:0]         w_frame;

    // Both requesting: serve the one not served last; otherwise the sole requester.
    always_comb begin
        w_win = 1'b0;
        if (bus.req_in == 2'b11) begin
            w_win = ~r_last;
        end else begin
            w_win = bus.req_in[1];
        end
    end

    assign w_reg   = w_win ? bus.reg_in[9:5]    : bus.reg_in[4:0];
    assign w_wr    = w_win ? bus.wr_in[1]       : bus.wr_in[0];
    assign w_wdata = w_win ? bus.wdata_in[15:8] : bus.wdata_in[7:0];
    assign w_frame = {w_reg, 1'b0, w_wr, 1'b0, (w_wr ? w_wdata : 8'h00)};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_last  <= 1'b1;
            r_grant <= 2'b00;
            r_done  <= 2'b00;
            r_rdata <= 8'h00;
            r_busy  <= 1'b0;
            r_ss    <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_in != 2'b00) begin
                        r_state <= S_SHIFT;
                        r_last  <= w_win;
                        r_grant <= w_win ? 2'b10 : 2'b01;
                        r_tx    <= w_frame;
                        r_mosi  <= w_frame[15];
                        r_ss    <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_div   <= '0;
                        r_bit   <= 4'd15;
                    end
                end
                S_SHIFT: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                            r_rx   <= {r_rx[c_RX_W-2:0], miso_in};
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit == 4'd0) begin
                                r_state <= S_END;
                                r_ss    <= 1'b1;
                                r_mosi  <= 1'b0;
                                r_done  <= r_grant;
                                r_grant <= 2'b00;
                                r_rdata <= r_rx[7:0];
                            end else begin
                                // Next bit goes out on the falling SCLK edge.
                                r_bit  <= r_bit - 4'd1;
                                r_mosi <= r_tx[14];
                                r_tx   <= {r_tx[14:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_END: begin
                    r_done  <= 2'b00;
                    r_gap   <= '0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap + 10'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SPI_ARB_STATUS_EN
    logic [7:0] r_status;

    // The status byte is the first MISO byte, left in the upper half of r_rx.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_status <= 8'h00;
        end else if (r_state == S_SHIFT && r_div == c_DIV_LAST && r_sclk && r_bit == 4'd0) begin
            r_status <= r_rx[15:8];
        end
    end

    assign bus.status_out = r_status;
`else
    assign bus.status_out = 8'h00;
`endif

    assign bus.grant_out = r_grant;
    assign bus.done_out  = r_done;
    assign bus.rdata_out = r_rdata;
    assign bus.busy_out  = r_busy;
    assign ss_out        = r_ss;
    assign sclk_out      = r_sclk;
    assign mosi_out      = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_arbiter
// Brief    : Self-checking bench for spi_reg_arbiter against a frame-timing
//            reference model; honours SPI_ARB_STATUS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_arbiter;

    localparam int c_CLK_DIV = 4;
    localparam int c_GAP     = 10;
    localparam int c_FRAME   = 32 * c_CLK_DIV;
`ifdef SPI_ARB_STATUS_EN
    localparam bit c_STATUS_EN = 1'b1;
`else
    localparam bit c_STATUS_EN = 1'b0;
`endif

    logic clk_in  = 1'b0;
    logic rst_in  = 1'b1;
    logic miso_in = 1'b0;
    logic ss_out, sclk_out, mosi_out;

    spi_reg_arbiter_if bus ();

    spi_reg_arbiter #(
        .CLK_DIV    (c_CLK_DIV),
        .GAP_CYCLES (c_GAP)
    ) u_dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .bus      (bus),
        .ss_out   (ss_out),
        .sclk_out (sclk_out),
        .mosi_out (mosi_out),
        .miso_in  (miso_in)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: frame position derived from the grant edge by arithmetic.
    bit          m_reset_next = 1'b1;
    bit          m_active     = 1'b0;
    bit          m_last       = 1'b1;
    bit          m_win        = 1'b0;
    int          m_g          = 0;
    logic [15:0] m_frame      = '0;
    logic [15:0] m_miso       = '0;
    logic [7:0]  exp_rdata    = 8'h00;
    logic [7:0]  exp_status   = 8'h00;
    int          edge_k       = 0;
    bit          force_miso_en   = 1'b0;
    logic [15:0] force_miso_word = '0;

    // Observations for the directed scenarios.
    logic [15:0] obs_mosi  = '0;
    int          obs_low   = 0;
    logic [15:0] last_mosi = '0;
    int          last_low  = 0;
    int          n_done    = 0;
    bit          grant_log[$];
    logic        prev_sclk = 1'b0;
    logic        prev_ss   = 1'b1;

    always @(negedge clk_in) begin : p_model
        int       o;
        int       o1;
        bit       in_frame;
        logic [1:0] e_onehot;
        logic [6:0] e_pins;
        logic     wr;
        logic [4:0] rg;
        logic [7:0] wd;

        edge_k++;
        if (m_reset_next) begin
            m_active   = 1'b0;
            m_last     = 1'b1;
            exp_rdata  = 8'h00;
            exp_status = 8'h00;
        end

        o        = edge_k - m_g;
        in_frame = m_active && (o >= 0) && (o < c_FRAME);
        e_onehot = m_win ? 2'b10 : 2'b01;
        if (m_active && o == c_FRAME) begin
            exp_rdata  = m_miso[7:0];
            exp_status = c_STATUS_EN ? m_miso[15:8] : 8'h00;
        end
        e_pins[6]   = !in_frame;
        e_pins[5]   = in_frame && (((o / c_CLK_DIV) % 2) == 1);
        e_pins[4]   = m_active && (o >= 0) && (o < c_FRAME + 1 + c_GAP);
        e_pins[3:2] = in_frame ? e_onehot : 2'b00;
        e_pins[1:0] = (m_active && o == c_FRAME) ? e_onehot : 2'b00;

        check("pins{ss,sclk,busy,grant,done}",
              32'({ss_out, sclk_out, bus.busy_out, bus.grant_out, bus.done_out}), 32'(e_pins));
        if (in_frame || m_reset_next)
            check("mosi", 32'(mosi_out), 32'(in_frame ? m_frame[15 - o / (2 * c_CLK_DIV)] : 1'b0));
        check("status_rdata", 32'({bus.status_out, bus.rdata_out}), 32'({exp_status, exp_rdata}));
        m_reset_next = 1'b0;

        // Observation of what actually went out on the wire.
        if (!ss_out) obs_low++;
        if (!prev_sclk && sclk_out && !ss_out) obs_mosi = {obs_mosi[14:0], mosi_out};
        if (!prev_ss && ss_out) begin
            last_mosi = obs_mosi;
            last_low  = obs_low;
            obs_low   = 0;
        end
        if (bus.done_out != 2'b00) begin
            n_done++;
            grant_log.push_back(bus.done_out[1]);
        end
        prev_sclk = sclk_out;
        prev_ss   = ss_out;

        // Predict the next edge from the inputs it will sample.
        if (rst_in) begin
            m_reset_next = 1'b1;
        end else if ((!m_active || (edge_k + 1 >= m_g + c_FRAME + 2 + c_GAP)) && bus.req_in != 2'b00) begin
            m_win   = (bus.req_in == 2'b11) ? ~m_last : bus.req_in[1];
            m_last  = m_win;
            rg      = m_win ? bus.reg_in[9:5]    : bus.reg_in[4:0];
            wr      = m_win ? bus.wr_in[1]       : bus.wr_in[0];
            wd      = m_win ? bus.wdata_in[15:8] : bus.wdata_in[7:0];
            m_frame = {rg, 1'b0, wr, 1'b0, (wr ? wd : 8'h00)};
            m_miso  = force_miso_en ? force_miso_word : 16'($urandom);
            m_g     = edge_k + 1;
            m_active = 1'b1;
        end

        // MISO model: bit j of the response is valid across bit j's window.
        o1 = edge_k + 1 - m_g;
        if (m_active && o1 >= 0 && o1 < c_FRAME)
            miso_in = m_miso[15 - o1 / (2 * c_CLK_DIV)];
        else
            miso_in = 1'($urandom);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int c = 0;
        while (n_done < target && c < budget) begin
            @(posedge clk_in);
            c++;
        end
        #1;
        check("done_count", 32'(n_done), 32'(target));
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (bus.busy_out !== 1'b0 && c < budget) tick(1);
        check("idle", 32'(bus.busy_out), 32'd0);
    endtask

    // Raise one request, hold it until granted, then release it.
    task automatic do_req(input int who, input logic [4:0] r, input logic w, input logic [7:0] d);
        int c = 0;
        if (who == 0) begin
            bus.reg_in[4:0] = r; bus.wr_in[0] = w; bus.wdata_in[7:0] = d;
        end else begin
            bus.reg_in[9:5] = r; bus.wr_in[1] = w; bus.wdata_in[15:8] = d;
        end
        bus.req_in[who] = 1'b1;
        while (bus.grant_out[who] !== 1'b1 && c < 2 * (c_FRAME + c_GAP + 4)) begin
            tick(1);
            c++;
        end
        check("granted", 32'(bus.grant_out[who]), 32'd1);
        bus.req_in[who] = 1'b0;
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : p_stim
        int d0;
        int base;
        bus.req_in   = 2'b11;
        bus.reg_in   = '0;
        bus.wr_in    = '0;
        bus.wdata_in = '0;
        rst_in       = 1'b1;
        tick(3);
        check("reset_ss",    32'(ss_out),         32'd1);
        check("reset_grant", 32'(bus.grant_out),  32'd0);
        rst_in = 1'b0;

        // Continuous dual requests alternate starting with requester 0.
        base = grant_log.size();
        wait_done(4, 4 * (c_FRAME + c_GAP + 4) + 10);
        bus.req_in = 2'b00;
        if (grant_log.size() >= base + 4)
            check("rr_order", 32'({grant_log[base], grant_log[base+1], grant_log[base+2], grant_log[base+3]}), 32'b0101);
        wait_idle(c_GAP + 10);

        // Requester 0 writes reg 17 with 0x10.
        d0 = n_done;
        do_req(0, 5'd17, 1'b1, 8'h10);
        wait_done(d0 + 1, c_FRAME + 10);
        check("wr17_mosi", 32'(last_mosi), 32'h8A10);
        check("wr17_ss_low", 32'(last_low), 32'd128);
        check("wr17_owner", 32'(grant_log[grant_log.size()-1]), 32'd0);

        // Requester 1 reads reg 13; chip answers A5, 5A.
        force_miso_word = 16'hA55A;
        force_miso_en   = 1'b1;
        d0 = n_done;
        do_req(1, 5'd13, 1'b0, 8'h77);
        force_miso_en = 1'b0;
        wait_done(d0 + 1, c_FRAME + 10);
        check("rd13_mosi",   32'(last_mosi),       32'h6800);
        check("rd13_rdata",  32'(bus.rdata_out),   32'h5A);
        check("rd13_status", 32'(bus.status_out),  c_STATUS_EN ? 32'hA5 : 32'h00);
        check("rd13_owner",  32'(grant_log[grant_log.size()-1]), 32'd1);

        // Write data changed mid-frame must not reach the wire.
        d0 = n_done;
        do_req(0, 5'd17, 1'b1, 8'h10);
        tick(40);
        bus.wdata_in[7:0] = 8'hFF;
        wait_done(d0 + 1, c_FRAME + 10);
        check("latched_mosi", 32'(last_mosi), 32'h8A10);

        // Reset during bit 7 aborts the frame without a completion pulse.
        wait_idle(c_GAP + 10);
        d0 = n_done;
        do_req(1, 5'd3, 1'b1, 8'hC3);
        tick(8 * 2 * c_CLK_DIV + 2);
        rst_in = 1'b1;
        tick(1);
        rst_in = 1'b0;
        check("abort_ss", 32'(ss_out), 32'd1);
        tick(c_FRAME);
        check("abort_no_done", 32'(n_done), 32'(d0));
        do_req(0, 5'd9, 1'b1, 8'h3C);
        wait_done(d0 + 1, c_FRAME + 10);
        check("clean_mosi",   32'(last_mosi), 32'h4A3C);
        check("clean_ss_low", 32'(last_low),  32'd128);

        // A request raised and withdrawn during GAP is never served.
        tick(1);
        bus.req_in[0] = 1'b1;
        tick(3);
        bus.req_in[0] = 1'b0;
        d0 = n_done;
        tick(c_GAP + 20);
        check("gap_withdraw_done", 32'(n_done), 32'(d0));
        check("gap_withdraw_busy", 32'(bus.busy_out), 32'd0);

        // Randomized traffic, checked cycle by cycle by the model.
        for (int i = 0; i < 50; i++) begin
            bus.req_in   = 2'($urandom);
            bus.reg_in   = 10'($urandom);
            bus.wr_in    = 2'($urandom);
            bus.wdata_in = 16'($urandom);
            tick($urandom_range(1, 180));
        end
        bus.req_in = 2'b00;
        wait_idle(c_FRAME + c_GAP + 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_reg_arbiter.md
SPI_REG_ARBITER -- requirements
Module: spi_reg_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk_in cycles; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 10: minimum clk_in cycles SS stays high between transactions; legal range 1..1023.
REQ-003 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_in  input  1  reset; synchronous, active-high.
REQ-005 req_in  input  2  per-requester level request; bit n belongs to requester n.
REQ-006 reg_in  input  10  register address; [4:0] is requester 0, [9:5] is requester 1.
REQ-007 wr_in  input  2  per-requester direction; 1 = write, 0 = read.
REQ-008 wdata_in  input  16  write data; [7:0] is requester 0, [15:8] is requester 1.
REQ-009 grant_out  output  2  one-hot owner of the current transaction; 0 when idle.
REQ-010 done_out  output  2  one-cycle completion pulse to the owning requester.
REQ-011 rdata_out  output  8  second MISO byte of the last transaction; valid from the done_out pulse until the next done_out pulse.
REQ-012 busy_out  output  1  high whenever state is not IDLE.
REQ-013 ss_out, sclk_out, mosi_out  output  1 each  SPI slave-select (active-low), clock and data to the MAX3421E.
REQ-014 miso_in  input  1  SPI data from the MAX3421E.
REQ-015 status_out  output  8  first MISO byte (chip status) of the last transaction.

Function
REQ-016 FSM states are IDLE, SHIFT, END and GAP.
REQ-017 IDLE with any req_in bit set: grant round-robin, preferring the requester not served last; when only one requests, that one wins.
REQ-018 Grant cycle actions: latch reg, wr and wdata of the winner; set grant_out; drive ss_out low and mosi_out to bit 15; enter SHIFT.
REQ-019 Frame is 16 bits, MSB first: command byte {reg[4:0], 0, wr, 0} followed by the data byte (wdata for a write, 0x00 for a read).
REQ-020 Per bit: sclk_out low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-021 mosi_out changes only while sclk_out is low.
REQ-022 miso_in is sampled on the cycle sclk_out rises.
REQ-023 After bit 0's high phase: enter END with sclk_out low; ss_out is therefore low for exactly 32*CLK_DIV cycles.
REQ-024 END lasts one cycle: ss_out high, done_out pulses on the granted bit, rdata_out updates, grant_out clears; next state is GAP.
REQ-025 GAP holds ss_out high for GAP_CYCLES cycles, then enters IDLE. Requests are ignored during GAP.
REQ-026 A req_in drop after grant does not abort the transaction. A req_in drop before grant withdraws the request.
REQ-027 Requester sampled in a grant cycle and still requesting after GAP competes again under round-robin; continuous dual requests therefore alternate 0,1,0,1.
REQ-028 Changes to reg_in, wr_in or wdata_in after the grant cycle do not affect the frame in flight.

Reset
REQ-029 While rst_in is high, next edge forces: state IDLE; ss_out 1; sclk_out 0; mosi_out 0; grant_out 0; done_out 0; busy_out 0; rdata_out 0x00; status_out 0x00; round-robin pointer set so requester 0 wins first.
REQ-030 Reset mid-SHIFT: ss_out high on the next edge; no done_out pulse for the aborted frame.

Configuration
REQ-031 Macro SPI_ARB_STATUS_EN defined: the first 8 sampled MISO bits are captured, and status_out updates in the END cycle.
REQ-032 Macro SPI_ARB_STATUS_EN undefined: status_out is tied to 0x00 and no capture logic is built; all other behaviour is identical.

Verification
REQ-033 Scenario: CLK_DIV=4; req0 writes reg 17, data 0x10 -> MOSI 0x8A then 0x10; ss_out low 128 cycles; done_out=01.
REQ-034 Scenario: req1 reads reg 13; MISO model returns 0xA5, 0x5A -> MOSI 0x68, 0x00; rdata_out=0x5A; done_out=10; status_out=0xA5 with macro, 0x00 without.
REQ-035 Scenario: req_in=11 held from reset -> grant order 0,1,0,1; ss_out high at least GAP_CYCLES cycles between frames.
REQ-036 Scenario: rst_in pulsed at bit 7 of a frame -> ss_out=1 next cycle; no done_out; next request yields a clean full 16-bit frame.
REQ-037 Scenario: req0 changes wdata_in from 0x10 to 0xFF mid-frame -> data byte shifted is still 0x10.
REQ-038 Scenario: req0 drops before grant (during GAP) -> no transaction for requester 0; busy_out falls after GAP.
